// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Arbitrates the single register-file write port between the
//             pipeline write-back stage and a multi-cycle unit (divider/load).
//             Multi-cycle results that lose arbitration wait in a 2-entry FIFO.
//             A newer pipeline write to the same register kills any older
//             buffered result, so the pipeline value is never overwritten.
//  Macro    : WB_STARVE_GUARD_EN - when defined, a buffered head that has been
//             blocked STARVE_LIMIT cycles takes the port and raises stall_req.
//  Ports    : clk, rst (async, active-low)
//             pipe_we/pipe_waddr/pipe_wdata   pipeline write-back request
//             mc_valid/mc_waddr/mc_wdata      multi-cycle result, mc_ready back
//             rf_we/rf_waddr/rf_wdata         register-file write port
//             mc_pending                      live result still buffered
//             stall_req                       hold pipeline write-back one cycle
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_we,
   input  logic [4:0]  pipe_waddr,
   input  logic [31:0] pipe_wdata,
   input  logic        mc_valid,
   input  logic [4:0]  mc_waddr,
   input  logic [31:0] mc_wdata,
   output logic        mc_ready,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        mc_pending,
   output logic        stall_req
);

   localparam logic [1:0] c_DEPTH = 2'd2;

   // The guard counter is 4 bits wide, so only 1..15 is meaningful.
   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
      $error("regfile_wb_arbiter: STARVE_LIMIT must be in 1..15");
   end

   logic [4:0]  r_addr [2];
   logic [31:0] r_data [2];
   logic [1:0]  r_live;
   logic        r_head;
   logic        r_tail;
   logic [1:0]  r_count;

   logic w_pipe_eff;
   logic w_mc_eff;
   logic w_empty;
   logic w_head_live;
   logic w_guard;
   logic w_sel_pipe;
   logic w_sel_head;
   logic w_sel_byp;
   logic w_pop;
   logic w_push;
   logic w_push_live;

   assign w_pipe_eff  = pipe_we && (pipe_waddr != 5'd0);
   assign w_mc_eff    = mc_valid && (mc_waddr != 5'd0);
   assign w_empty     = (r_count == 2'd0);
   assign w_head_live = !w_empty && r_live[r_head];
   assign mc_ready    = (r_count < c_DEPTH);

`ifdef WB_STARVE_GUARD_EN
   localparam logic [3:0] c_LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] r_starve;

   assign w_guard = rst && w_head_live && (r_starve == c_LIMIT);

   // Counts cycles the live head loses to the pipe; any head grant or a
   // missing live head restarts the count.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_starve <= 4'd0;
      end else if (!w_head_live || w_sel_head) begin
         r_starve <= 4'd0;
      end else if (w_sel_pipe) begin
         r_starve <= r_starve + 4'd1;
      end
   end
`else
   assign w_guard = 1'b0;
`endif

   assign stall_req = w_guard;

   // Grant priority: guard, pipe, live head, direct bypass. All grants are
   // gated by rst so nothing reaches the register file while in reset.
   assign w_sel_head = w_guard || (rst && !w_pipe_eff && w_head_live);
   assign w_sel_pipe = rst && !w_guard && w_pipe_eff;
   assign w_sel_byp  = rst && !w_guard && !w_pipe_eff && w_empty && w_mc_eff;

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = 5'd0;
      rf_wdata = 32'd0;
      if (w_sel_head) begin
         rf_we    = 1'b1;
         rf_waddr = r_addr[r_head];
         rf_wdata = r_data[r_head];
      end else if (w_sel_pipe) begin
         rf_we    = 1'b1;
         rf_waddr = pipe_waddr;
         rf_wdata = pipe_wdata;
      end else if (w_sel_byp) begin
         rf_we    = 1'b1;
         rf_waddr = mc_waddr;
         rf_wdata = mc_wdata;
      end
   end

   // A dead head needs no port, so it drains on any cycle.
   assign w_pop  = !w_empty && (w_sel_head || !r_live[r_head]);
   // Address-0 handshakes and bypassed results never enter the FIFO.
   assign w_push = mc_valid && mc_ready && (mc_waddr != 5'd0) && !w_sel_byp;
   // A result arriving alongside a same-address pipe write is already stale.
   assign w_push_live = !(w_sel_pipe && (mc_waddr == pipe_waddr));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head  <= 1'b0;
         r_tail  <= 1'b0;
         r_count <= 2'd0;
         r_live  <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            r_addr[i] <= 5'd0;
            r_data[i] <= 32'd0;
         end
      end else begin
         // WAW kill: a granted pipe write supersedes buffered results.
         // Stale slots may match too; their live bit is already clear.
         for (int i = 0; i < 2; i++) begin
            if (w_sel_pipe && (r_addr[i] == pipe_waddr)) begin
               r_live[i] <= 1'b0;
            end
         end
         if (w_pop) begin
            r_live[r_head] <= 1'b0;
            r_head         <= ~r_head;
         end
         // Push and pop never share a slot: pop needs count>=1 and push
         // needs count<=1, so they target different entries.
         if (w_push) begin
            r_addr[r_tail] <= mc_waddr;
            r_data[r_tail] <= mc_wdata;
            r_live[r_tail] <= w_push_live;
            r_tail         <= ~r_tail;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   // Popped slots have their live bit cleared, so live implies buffered.
   assign mc_pending = |r_live;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Directed self-checking bench for regfile_wb_arbiter. Inputs are
//             driven 1 ns after the rising edge, outputs sampled on the
//             falling edge. Honours WB_STARVE_GUARD_EN for the starvation case.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        pipe_we;
   logic [4:0]  pipe_waddr;
   logic [31:0] pipe_wdata;
   logic        mc_valid;
   logic [4:0]  mc_waddr;
   logic [31:0] mc_wdata;
   logic        mc_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        mc_pending;
   logic        stall_req;

   int n_cmp = 0;
   int n_err = 0;

   regfile_wb_arbiter #(
      .STARVE_LIMIT (4)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .pipe_we    (pipe_we),
      .pipe_waddr (pipe_waddr),
      .pipe_wdata (pipe_wdata),
      .mc_valid   (mc_valid),
      .mc_waddr   (mc_waddr),
      .mc_wdata   (mc_wdata),
      .mc_ready   (mc_ready),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .mc_pending (mc_pending),
      .stall_req  (stall_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md);
      pipe_we    = pwe;
      pipe_waddr = pa;
      pipe_wdata = pd;
      mc_valid   = mv;
      mc_waddr   = ma;
      mc_wdata   = md;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Expected write port value in one call.
   task automatic check_wr(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
      check_eq({tag, ".we"},   32'(rf_we),    32'(we));
      check_eq({tag, ".addr"}, 32'(rf_waddr), 32'(a));
      check_eq({tag, ".data"}, rf_wdata,      d);
   endtask

   initial begin
      rst = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      repeat (2) @(posedge clk);
      smp();
      check_eq("rst.mc_ready",   32'(mc_ready),   32'd1);
      check_eq("rst.rf_we",      32'(rf_we),      32'd0);
      check_eq("rst.mc_pending", 32'(mc_pending), 32'd0);
      check_eq("rst.stall_req",  32'(stall_req),  32'd0);
      nxt();
      rst = 1'b1;

      // Direct bypass, written in the same cycle, nothing buffered
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hA5A5_A5A5);
      smp();
      check_wr("byp", 1'b1, 5'd5, 32'hA5A5_A5A5);
      check_eq("byp.mc_ready", 32'(mc_ready), 32'd1);
      nxt();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      smp();
      check_wr("byp.after", 1'b0, 5'd0, 32'd0);
      check_eq("byp.pending", 32'(mc_pending), 32'd0);
      nxt();

      // Pipe holds the port; two mc results are buffered, then drain in order
      drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
      smp();
      check_wr("fill.c0", 1'b1, 5'd3, 32'h33);
      nxt();
      drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd8, 32'h88);
      smp();
      check_eq("fill.c1.ready",   32'(mc_ready),   32'd1);
      check_eq("fill.c1.pending", 32'(mc_pending), 32'd1);
      check_wr("fill.c1", 1'b1, 5'd3, 32'h33);
      nxt();
      drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
      smp();
      check_eq("fill.c2.ready", 32'(mc_ready), 32'd0);
      check_wr("fill.c2", 1'b1, 5'd3, 32'h33);
      nxt();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      smp();
      check_wr("drain.7", 1'b1, 5'd7, 32'h77);
      check_eq("drain.7.ready", 32'(mc_ready), 32'd0);
      nxt();
      smp();
      check_wr("drain.8", 1'b1, 5'd8, 32'h88);
      check_eq("drain.8.ready", 32'(mc_ready), 32'd1);
      nxt();
      smp();
      check_wr("drain.idle", 1'b0, 5'd0, 32'd0);
      check_eq("drain.pending", 32'(mc_pending), 32'd0);

      // WAW: buffered addr 9 killed by a later pipe write to addr 9
      nxt();
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h11);
      nxt();
      drive(1'b1, 5'd9, 32'h22, 1'b0, 5'd0, 32'd0);
      smp();
      check_wr("waw.pipe", 1'b1, 5'd9, 32'h22);
      check_eq("waw.pending.before", 32'(mc_pending), 32'd1);
      nxt();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      smp();
      check_wr("waw.deadpop", 1'b0, 5'd0, 32'd0);
      check_eq("waw.pending.after", 32'(mc_pending), 32'd0);
      nxt();
      smp();
      check_wr("waw.idle", 1'b0, 5'd0, 32'd0);
      check_eq("waw.ready", 32'(mc_ready), 32'd1);

      // Address-0 handshakes are accepted and dropped
      nxt();
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD);
      smp();
      check_eq("zero.ready", 32'(mc_ready), 32'd1);
      check_eq("zero.we",    32'(rf_we),    32'd0);
      nxt();
      smp();
      check_eq("zero.we2",   32'(rf_we),      32'd0);
      check_eq("zero.pend",  32'(mc_pending), 32'd0);
      nxt();
      smp();
      check_eq("zero.ready3", 32'(mc_ready), 32'd1);
      nxt();

      // Starvation: one live entry buffered under a continuous pipe stream
      drive(1'b1, 5'd2, 32'h2, 1'b1, 5'd10, 32'hAA);
      nxt();
      drive(1'b1, 5'd2, 32'h2, 1'b0, 5'd0, 32'd0);
      for (int k = 1; k <= 4; k++) begin
         smp();
         check_eq($sformatf("starve.c%0d.stall", k), 32'(stall_req), 32'd0);
         check_eq($sformatf("starve.c%0d.addr", k),  32'(rf_waddr),  32'd2);
         nxt();
      end
`ifdef WB_STARVE_GUARD_EN
      smp();
      check_eq("starve.c5.stall", 32'(stall_req), 32'd1);
      check_wr("starve.c5", 1'b1, 5'd10, 32'hAA);
      nxt();
      smp();
      check_eq("starve.c6.stall", 32'(stall_req), 32'd0);
      check_wr("starve.c6", 1'b1, 5'd2, 32'h2);
      check_eq("starve.c6.pending", 32'(mc_pending), 32'd0);
      nxt();
`else
      smp();
      check_eq("starve.c5.stall", 32'(stall_req), 32'd0);
      check_wr("starve.c5", 1'b1, 5'd2, 32'h2);
      check_eq("starve.c5.pending", 32'(mc_pending), 32'd1);
      nxt();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      smp();
      check_wr("starve.drop", 1'b1, 5'd10, 32'hAA);
      nxt();
`endif
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      smp();
      check_eq("starve.end.pending", 32'(mc_pending), 32'd0);
      nxt();

      // Reset with two entries buffered discards them
      drive(1'b1, 5'd4, 32'h4, 1'b1, 5'd11, 32'hB1);
      nxt();
      drive(1'b1, 5'd4, 32'h4, 1'b1, 5'd12, 32'hB2);
      nxt();
      drive(1'b1, 5'd4, 32'h4, 1'b1, 5'd13, 32'hB3);
      smp();
      check_eq("full.ready",   32'(mc_ready),   32'd0);
      check_eq("full.pending", 32'(mc_pending), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      check_eq("mrst.we",      32'(rf_we),      32'd0);
      check_eq("mrst.ready",   32'(mc_ready),   32'd1);
      check_eq("mrst.pending", 32'(mc_pending), 32'd0);
      check_eq("mrst.stall",   32'(stall_req),  32'd0);
      nxt();
      nxt();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         smp();
         check_eq($sformatf("post.c%0d.we", k),      32'(rf_we),      32'd0);
         check_eq($sformatf("post.c%0d.pending", k), 32'(mc_pending), 32'd0);
         nxt();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
